// File: rtl/fp_butterfly_r2.sv
// Radix-2 complex FP butterfly: S = X + Y, D = X - Y, one shared adder over four cycles.
// Ports: i_clk/i_rst; i_valid/o_ready + i_xr,i_xi,i_yr,i_yi in; o_valid/i_ready + o_sr,o_si,o_dr,o_di,o_exc out; o_busy.

// Single-precision add/subtract, round-to-nearest-even, denormals kept, any NaN -> NAN_CANON.
// Ports: a, b operands; i_control 0 = a + b, 1 = a - b; result.
module fpu_add_sub #(
    parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        i_control,
    output logic [31:0] result
);
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic        bs, ss, rnd;
    logic [7:0]  be, se, eb, es, d;
    logic [22:0] bf, sf, fr;
    logic [26:0] mb, ms, msh, n;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e, ef;
    logic [24:0] rm;

    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ i_control;
        a_nan = (&a[30:23]) & (|a[22:0]);
        b_nan = (&b[30:23]) & (|b[22:0]);
        a_inf = (&a[30:23]) & ~(|a[22:0]);
        b_inf = (&b[30:23]) & ~(|b[22:0]);

        // Order by magnitude so the subtraction below never goes negative.
        swap = b[30:0] > a[30:0];
        bs   = swap ? sb : sa;
        ss   = swap ? sa : sb;
        be   = swap ? b[30:23] : a[30:23];
        se   = swap ? a[30:23] : b[30:23];
        bf   = swap ? b[22:0] : a[22:0];
        sf   = swap ? a[22:0] : b[22:0];
        mb   = {|be, bf, 3'b000};
        ms   = {|se, sf, 3'b000};
        eb   = (be == 8'd0) ? 8'd1 : be;
        es   = (se == 8'd0) ? 8'd1 : se;
        d    = eb - es;

        // Align with guard/round bits and a sticky bit in bit 0.
        if (d > 8'd26)
            msh = {26'b0, |ms};
        else
            msh = (ms >> d) | {26'b0, |(ms & ((27'd1 << d) - 27'd1))};

        sum = (bs ^ ss) ? {1'b0, mb} - {1'b0, msh}
                        : {1'b0, mb} + {1'b0, msh};

        lz = 5'd26;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);

        // Normalise; left shift stops at the denormal boundary.
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = {2'b0, eb} + 10'd1;
        end else if (eb > {3'b0, lz}) begin
            n = sum[26:0] << lz;
            e = {2'b0, eb} - {5'b0, lz};
        end else begin
            n = sum[26:0] << (eb - 8'd1);
            e = 10'd0;
        end

        rnd = n[2] & (n[1] | n[0] | n[3]);
        rm  = {1'b0, n[26:3]} + {24'b0, rnd};
        ef  = e;
        fr  = rm[22:0];
        if (rm[24]) begin
            ef = e + 10'd1;
            fr = rm[23:1];
        end else if (e == 10'd0 && rm[23]) begin
            ef = 10'd1;
        end

        if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb)))
            result = NAN_CANON;
        else if (a_inf)
            result = {sa, 8'hFF, 23'b0};
        else if (b_inf)
            result = {sb, 8'hFF, 23'b0};
        else if (sum == 28'd0)
            result = {bs & ss, 31'b0};
        else if (ef >= 10'd255)
            result = {bs, 8'hFF, 23'b0};
        else
            result = {bs, ef[7:0], fr};
    end
endmodule

module fp_butterfly_r2 #(
    parameter bit          SCALE_HALF = 1'b0,
    parameter logic [31:0] NAN_CANON  = 32'h7FC00000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_xr,
    input  logic [31:0] i_xi,
    input  logic [31:0] i_yr,
    input  logic [31:0] i_yi,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_sr,
    output logic [31:0] o_si,
    output logic [31:0] o_dr,
    output logic [31:0] o_di,
    output logic        o_exc,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, OP0, OP1, OP2, OP3, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] xr_q, xi_q, yr_q, yi_q;
    logic [31:0] add_a, add_b, add_res, res;
    logic        add_ctl, accept, real_op;

    assign o_ready = (state == IDLE) | ((state == HOLD) & i_ready);
    assign o_valid = (state == HOLD);
    assign o_busy  = (state == OP0) | (state == OP1) |
                     (state == OP2) | (state == OP3);
    assign accept  = i_valid & o_ready;
    assign real_op = (state == OP0) | (state == OP1);
    assign add_a   = real_op ? xr_q : xi_q;
    assign add_b   = real_op ? yr_q : yi_q;
    assign add_ctl = (state == OP1) | (state == OP3);

    fpu_add_sub #(.NAN_CANON(NAN_CANON)) u_add (
        .a         (add_a),
        .b         (add_b),
        .i_control (add_ctl),
        .result    (add_res)
    );

    // Halving: Inf/NaN pass, exponents 0/1 flush to signed zero.
    always_comb begin
        res = add_res;
        if (SCALE_HALF && add_res[30:23] != 8'hFF) begin
            if (add_res[30:23] >= 8'd2)
                res = {add_res[31], add_res[30:23] - 8'd1, add_res[22:0]};
            else
                res = {add_res[31], 31'b0};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = OP0;
            OP0:     state_nx = OP1;
            OP1:     state_nx = OP2;
            OP2:     state_nx = OP3;
            OP3:     state_nx = HOLD;
            HOLD:    if (i_ready) state_nx = i_valid ? OP0 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            xr_q  <= '0;
            xi_q  <= '0;
            yr_q  <= '0;
            yi_q  <= '0;
            o_sr  <= '0;
            o_si  <= '0;
            o_dr  <= '0;
            o_di  <= '0;
            o_exc <= 1'b0;
        end else if (accept) begin
            xr_q  <= i_xr;
            xi_q  <= i_xi;
            yr_q  <= i_yr;
            yi_q  <= i_yi;
            o_exc <= 1'b0;
        end else if (o_busy) begin
            o_exc <= o_exc | (&res[30:23]);
            case (state)
                OP0:     o_sr <= res;
                OP1:     o_dr <= res;
                OP2:     o_si <= res;
                default: o_di <= res;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_butterfly_r2.sv
// Directed bench for fp_butterfly_r2: unscaled and halving instances driven in lockstep.
// Checks reset, latency, arithmetic, rounding, exceptions, backpressure, back-to-back and mid-op reset.
module tb_fp_butterfly_r2;
    logic        clk, rst, in_valid, out_ready;
    logic [31:0] xr, xi, yr, yi;
    logic        rdy, vld, exc, busy;
    logic        rdy_s, vld_s, exc_s, busy_s;
    logic [31:0] sr, si, dr, di, sr_s, si_s, dr_s, di_s;
    int          n_vec, n_err;

    fp_butterfly_r2 #(.SCALE_HALF(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy),
        .i_xr(xr), .i_xi(xi), .i_yr(yr), .i_yi(yi),
        .o_valid(vld), .i_ready(out_ready),
        .o_sr(sr), .o_si(si), .o_dr(dr), .o_di(di),
        .o_exc(exc), .o_busy(busy)
    );

    fp_butterfly_r2 #(.SCALE_HALF(1'b1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_s),
        .i_xr(xr), .i_xi(xi), .i_yr(yr), .i_yi(yi),
        .o_valid(vld_s), .i_ready(out_ready),
        .o_sr(sr_s), .o_si(si_s), .o_dr(dr_s), .o_di(di_s),
        .o_exc(exc_s), .o_busy(busy_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, b, c, d);
        xr = a;
        xi = b;
        yr = c;
        yi = d;
    endtask

    // Called right after the accept edge; results appear on the 4th edge.
    task automatic latency(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_rdy"}, {31'b0, rdy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk({tag, "_vld_early"}, {31'b0, vld}, 32'd0);
        end
        step();
        chk({tag, "_vld"}, {31'b0, vld}, 32'd1);
        chk({tag, "_vld_s"}, {31'b0, vld_s}, 32'd1);
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_res(input string tag,
                           input logic [31:0] esr, esi, edr, edi,
                           input logic eexc,
                           input logic [31:0] hsr, hsi, hdr, hdi);
        chk({tag, "_sr"}, sr, esr);
        chk({tag, "_si"}, si, esi);
        chk({tag, "_dr"}, dr, edr);
        chk({tag, "_di"}, di, edi);
        chk({tag, "_exc"}, {31'b0, exc}, {31'b0, eexc});
        chk({tag, "_sr_s"}, sr_s, hsr);
        chk({tag, "_si_s"}, si_s, hsi);
        chk({tag, "_dr_s"}, dr_s, hdr);
        chk({tag, "_di_s"}, di_s, hdi);
        chk({tag, "_exc_s"}, {31'b0, exc_s}, {31'b0, eexc});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        #12;
        chk("rst_vld", {31'b0, vld}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdy", {31'b0, rdy}, 32'd1);
        chk_res("rst", 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();

        // Basic: 1+2j and 2+1j.
        out_ready = 1'b1;
        drive(32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000);
        in_valid = 1'b1;
        chk("t1_rdy_idle", {31'b0, rdy}, 32'd1);
        step();
        in_valid = 1'b0;
        drive(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        latency("t1");
        chk_res("t1", 32'h40400000, 32'h40400000, 32'hBF800000,
                32'h3F800000, 1'b0, 32'h3FC00000, 32'h3FC00000,
                32'hBF000000, 32'h3F000000);
        step();
        chk("t1_idle_vld", {31'b0, vld}, 32'd0);
        chk("t1_idle_rdy", {31'b0, rdy}, 32'd1);
        chk("t1_held_sr", sr, 32'h40400000);

        // Smallest-normal operand: halving flushes to signed zero.
        out_ready = 1'b0;
        drive(32'h80800000, 32'h3F800000, 32'h00000000, 32'h00000000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        latency("t2");
        chk_res("t2", 32'h80800000, 32'h3F800000, 32'h80800000,
                32'h3F800000, 1'b0, 32'h80000000, 32'h3F000000,
                32'h80000000, 32'h3F000000);

        // Backpressure: stall three cycles with valid offered, no capture.
        drive(32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_vld", {31'b0, vld}, 32'd1);
            chk("bp_rdy", {31'b0, rdy}, 32'd0);
            chk("bp_sr", sr, 32'h80800000);
            chk("bp_di", di, 32'h3F800000);
        end
        drive(32'h7F800000, 32'h00000000, 32'h7F800000, 32'h00000000);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", {31'b0, rdy}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_vld_drop", {31'b0, vld}, 32'd0);
        latency("t3");
        chk_res("t3", 32'h7F800000, 32'h00000000, 32'h7FC00000,
                32'h00000000, 1'b1, 32'h7F800000, 32'h00000000,
                32'h7FC00000, 32'h00000000);

        // Back-to-back, one accept every 5 cycles.
        in_valid = 1'b1;
        drive(32'h40490FDB, 32'hC0490FDB, 32'h40490FDB, 32'hC0490FDB);
        step();
        latency("b0");
        chk_res("b0", 32'h40C90FDB, 32'hC0C90FDB, 32'h00000000,
                32'h00000000, 1'b0, 32'h40490FDB, 32'hC0490FDB,
                32'h00000000, 32'h00000000);
        drive(32'h41200000, 32'hC0A00000, 32'h3F000000, 32'h40A00000);
        step();
        latency("b1");
        chk_res("b1", 32'h41280000, 32'h00000000, 32'h41180000,
                32'hC1200000, 1'b0, 32'h40A80000, 32'h00000000,
                32'h40980000, 32'hC0A00000);
        drive(32'h3F800000, 32'h3F800001, 32'h33800000, 32'h33800000);
        step();
        in_valid = 1'b0;
        latency("b2");
        chk_res("b2", 32'h3F800000, 32'h3F800002, 32'h3F7FFFFF,
                32'h3F800000, 1'b0, 32'h3F000000, 32'h3F000002,
                32'h3EFFFFFF, 32'h3F000000);
        step();

        // Reset during OP2 clears everything without a clock edge.
        drive(32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_sr_pre", sr, 32'h40400000);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_vld", {31'b0, vld}, 32'd0);
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk_res("mid", 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mid_rdy", {31'b0, rdy}, 32'd1);
        step();
        drive(32'h41200000, 32'hC0A00000, 32'h3F000000, 32'h40A00000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        latency("post");
        chk_res("post", 32'h41280000, 32'h00000000, 32'h41180000,
                32'hC1200000, 1'b0, 32'h40A80000, 32'h00000000,
                32'h40980000, 32'hC0A00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
